// File: rtl/letc_core_stage_mem2_if.sv
// Signal bundle between the LETC M2 stage and its neighbours (M1, DMSS, writeback, hazard unit).
// The stage itself uses the slave modport; the environment driving it uses master.
interface letc_core_stage_mem2_if;
  logic        m2_ready;
  logic        m2_flush;
  logic        m2_stall;
  logic        m1_to_m2_valid;
  logic [4:0]  in_rd_idx;
  logic        in_rd_we;
  logic [1:0]  in_rd_src;
  logic [31:0] in_alu_result;
  logic [31:0] in_csr_old_val;
  logic        in_is_load;
  logic [1:0]  in_mem_size;
  logic        in_mem_signed;
  logic        dmss_rvalid;
  logic [31:0] dmss_rdata;
  logic        m2_to_w_valid;
  logic [4:0]  out_rd_idx;
  logic        out_rd_we;
  logic [1:0]  out_rd_src;
  logic [31:0] out_alu_result;
  logic [31:0] out_mem_rdata;
  logic [31:0] out_csr_old_val;
  logic        fwd_valid;
  logic [4:0]  fwd_rd_idx;
  logic [31:0] fwd_rd_val;

  modport slave (
    input  m2_flush, m2_stall, m1_to_m2_valid, in_rd_idx, in_rd_we, in_rd_src,
           in_alu_result, in_csr_old_val, in_is_load, in_mem_size, in_mem_signed,
           dmss_rvalid, dmss_rdata,
    output m2_ready, m2_to_w_valid, out_rd_idx, out_rd_we, out_rd_src, out_alu_result,
           out_mem_rdata, out_csr_old_val, fwd_valid, fwd_rd_idx, fwd_rd_val
  );

  modport master (
    output m2_flush, m2_stall, m1_to_m2_valid, in_rd_idx, in_rd_we, in_rd_src,
           in_alu_result, in_csr_old_val, in_is_load, in_mem_size, in_mem_signed,
           dmss_rvalid, dmss_rdata,
    input  m2_ready, m2_to_w_valid, out_rd_idx, out_rd_we, out_rd_src, out_alu_result,
           out_mem_rdata, out_csr_old_val, fwd_valid, fwd_rd_idx, fwd_rd_val
  );
endinterface

// File: rtl/letc_core_stage_mem2.sv
// LETC M2 stage: holds the M1 result, waits for the in-order DMSS load response,
// formats load data and presents it to writeback and the forwarding network.
module letc_core_stage_mem2 #(
  parameter int unsigned MAX_DISCARD = 3
) (
  input logic                  clk,
  input logic                  rst_n,
  letc_core_stage_mem2_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(MAX_DISCARD + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HELD = 2'd2
  } state_e;

  state_e           state, state_nxt;
  logic [CNT_W-1:0] discard_cnt, discard_nxt;
  logic [31:0]      rdata_hold;

  logic        ff_in_valid;
  logic [4:0]  rd_idx_q;
  logic        rd_we_q;
  logic [1:0]  rd_src_q;
  logic [31:0] alu_result_q;
  logic [31:0] csr_old_val_q;
  logic        is_load_q;
  logic [1:0]  mem_size_q;
  logic        mem_signed_q;

  logic        capture, load_capture, discard_pending;
  logic        resp_take, resp_drop, kill_pending, data_avail;
  logic [31:0] raw, mem_rdata, fwd_val;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign capture         = !bus.m2_stall;
  assign load_capture    = capture && bus.m1_to_m2_valid && bus.in_is_load;
  assign discard_pending = (discard_cnt != '0);
  assign resp_take       = (state == ST_WAIT) && bus.dmss_rvalid && !discard_pending;
  assign resp_drop       = bus.dmss_rvalid && discard_pending;
  // A killed load still owes us a response; remember to swallow it.
  assign kill_pending    = bus.m2_flush && (state == ST_WAIT) && !resp_take;

  always_ff @(posedge clk) begin
    if (!rst_n)             ff_in_valid <= 1'b0;
    else if (capture)       ff_in_valid <= bus.m1_to_m2_valid;
    else if (bus.m2_flush)  ff_in_valid <= 1'b0;
  end

  // NOTE: payload is qualified by ff_in_valid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      rd_idx_q      <= bus.in_rd_idx;
      rd_we_q       <= bus.in_rd_we;
      rd_src_q      <= bus.in_rd_src;
      alu_result_q  <= bus.in_alu_result;
      csr_old_val_q <= bus.in_csr_old_val;
      is_load_q     <= bus.in_is_load;
      mem_size_q    <= bus.in_mem_size;
      mem_signed_q  <= bus.in_mem_signed;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      discard_cnt <= '0;
    end else begin
      state       <= state_nxt;
      discard_cnt <= discard_nxt;
    end
  end

  // NOTE: every output of a combinational block is defaulted first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    if (capture)           state_nxt = load_capture ? ST_WAIT : ST_IDLE;
    else if (bus.m2_flush) state_nxt = ST_IDLE;
    else if (resp_take)    state_nxt = ST_HELD;
  end

  always_comb begin
    discard_nxt = discard_cnt;
    if (kill_pending && !resp_drop)      discard_nxt = discard_cnt + 1'b1;
    else if (resp_drop && !kill_pending) discard_nxt = discard_cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (resp_take) rdata_hold <= bus.dmss_rdata;
  end

  assign data_avail = !is_load_q || (state == ST_HELD) || resp_take;

  always_comb begin
    raw = resp_take ? bus.dmss_rdata : rdata_hold;
    case (alu_result_q[1:0])
      2'd0:    byte_v = raw[7:0];
      2'd1:    byte_v = raw[15:8];
      2'd2:    byte_v = raw[23:16];
      default: byte_v = raw[31:24];
    endcase
    half_v = alu_result_q[1] ? raw[31:16] : raw[15:0];
    case (mem_size_q)
      2'd0:    mem_rdata = {{24{mem_signed_q & byte_v[7]}}, byte_v};
      2'd1:    mem_rdata = {{16{mem_signed_q & half_v[15]}}, half_v};
      default: mem_rdata = raw;
    endcase
  end

  always_comb begin
    case (rd_src_q)
      2'd0:    fwd_val = alu_result_q;
      2'd1:    fwd_val = mem_rdata;
      2'd2:    fwd_val = csr_old_val_q;
      default: fwd_val = 32'hDEAD_BEEF;
    endcase
  end

  assign bus.m2_ready        = !ff_in_valid || bus.m2_flush || data_avail;
  assign bus.m2_to_w_valid   = ff_in_valid && data_avail && !bus.m2_flush && !bus.m2_stall;
  assign bus.out_rd_idx      = rd_idx_q;
  assign bus.out_rd_we       = rd_we_q;
  assign bus.out_rd_src      = rd_src_q;
  assign bus.out_alu_result  = alu_result_q;
  assign bus.out_mem_rdata   = mem_rdata;
  assign bus.out_csr_old_val = csr_old_val_q;
  assign bus.fwd_valid       = ff_in_valid && rd_we_q && data_avail && !bus.m2_flush;
  assign bus.fwd_rd_idx      = rd_idx_q;
  assign bus.fwd_rd_val      = fwd_val;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(kill_pending && !resp_drop && discard_cnt == CNT_W'(MAX_DISCARD)))
        else $fatal(1, "letc_core_stage_mem2: discard counter overflow");
      assert (!(state == ST_IDLE && bus.dmss_rvalid && !discard_pending))
        else $error("letc_core_stage_mem2: load response with no load pending");
    end
  end
endmodule

// File: tb/tb_letc_core_stage_mem2.sv
// Directed bench for the LETC M2 stage: inputs change on the falling edge and
// outputs are sampled 1ns later, well away from the rising edge.
module tb_letc_core_stage_mem2;
  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  letc_core_stage_mem2_if bus ();

  letc_core_stage_mem2 #(.MAX_DISCARD(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic drive_instr(input logic [4:0] rd, input logic we, input logic [1:0] src,
                             input logic [31:0] alu, input logic [31:0] csr, input logic ld,
                             input logic [1:0] size, input logic sgn);
    bus.m1_to_m2_valid = 1'b1;
    bus.in_rd_idx      = rd;
    bus.in_rd_we       = we;
    bus.in_rd_src      = src;
    bus.in_alu_result  = alu;
    bus.in_csr_old_val = csr;
    bus.in_is_load     = ld;
    bus.in_mem_size    = size;
    bus.in_mem_signed  = sgn;
  endtask

  task automatic drive_bubble();
    bus.m1_to_m2_valid = 1'b0;
    bus.in_is_load     = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_bubble();
    drive_instr(5'd0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 2'd2, 1'b0);
    bus.m1_to_m2_valid = 1'b0;
    bus.m2_flush = 1'b0; bus.m2_stall = 1'b0;
    bus.dmss_rvalid = 1'b0; bus.dmss_rdata = 32'h0;
    cyc(); cyc();
    #1;
    checks++; if (bus.m2_to_w_valid !== 1'b0) begin errors++; $display("FAIL rst_w_valid: got %b want 0", bus.m2_to_w_valid); end
    checks++; if (bus.m2_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", bus.m2_ready); end
    checks++; if (bus.fwd_valid !== 1'b0) begin errors++; $display("FAIL rst_fwd_valid: got %b want 0", bus.fwd_valid); end
    checks++; if (dut.state !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d want 0", dut.state); end
    rst_n = 1'b1;
  endtask

  task automatic test_alu_back_to_back();
    cyc(); drive_instr(5'd5, 1'b1, 2'd0, 32'h0000_1234, 32'h0, 1'b0, 2'd2, 1'b0);
    cyc(); drive_instr(5'd6, 1'b1, 2'd2, 32'h0000_0099, 32'h0000_C5C5, 1'b0, 2'd2, 1'b0);
    #1;
    checks++; if (bus.m2_to_w_valid !== 1'b1) begin errors++; $display("FAIL alu_w_valid: got %b want 1", bus.m2_to_w_valid); end
    checks++; if (bus.m2_ready !== 1'b1) begin errors++; $display("FAIL alu_ready: got %b want 1", bus.m2_ready); end
    checks++; if (bus.fwd_valid !== 1'b1) begin errors++; $display("FAIL alu_fwd_valid: got %b want 1", bus.fwd_valid); end
    checks++; if (bus.fwd_rd_idx !== 5'd5) begin errors++; $display("FAIL alu_fwd_idx: got %0d want 5", bus.fwd_rd_idx); end
    checks++; if (bus.fwd_rd_val !== 32'h0000_1234) begin errors++; $display("FAIL alu_fwd_val: got %h want 00001234", bus.fwd_rd_val); end
    cyc(); drive_instr(5'd7, 1'b1, 2'd3, 32'h0000_0077, 32'h0, 1'b0, 2'd2, 1'b0);
    #1;
    checks++; if (bus.fwd_rd_val !== 32'h0000_C5C5) begin errors++; $display("FAIL csr_fwd_val: got %h want 0000c5c5", bus.fwd_rd_val); end
    checks++; if (bus.out_csr_old_val !== 32'h0000_C5C5) begin errors++; $display("FAIL csr_out: got %h want 0000c5c5", bus.out_csr_old_val); end
    cyc(); drive_bubble();
    #1;
    checks++; if (bus.fwd_rd_val !== 32'hDEAD_BEEF) begin errors++; $display("FAIL badsrc_fwd_val: got %h want deadbeef", bus.fwd_rd_val); end
    checks++; if (bus.m2_to_w_valid !== 1'b1) begin errors++; $display("FAIL badsrc_w_valid: got %b want 1", bus.m2_to_w_valid); end
    cyc(); #1;
    checks++; if (bus.m2_to_w_valid !== 1'b0) begin errors++; $display("FAIL bubble_w_valid: got %b want 0", bus.m2_to_w_valid); end
    checks++; if (bus.fwd_valid !== 1'b0) begin errors++; $display("FAIL bubble_fwd_valid: got %b want 0", bus.fwd_valid); end
  endtask

  task automatic test_lb_signed();
    cyc(); drive_instr(5'd8, 1'b1, 2'd1, 32'h0000_1003, 32'h0, 1'b1, 2'd0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      cyc(); drive_bubble(); bus.m2_stall = 1'b1;
      #1;
      checks++; if (bus.m2_ready !== 1'b0) begin errors++; $display("FAIL lb_wait_ready[%0d]: got %b want 0", i, bus.m2_ready); end
      checks++; if (bus.m2_to_w_valid !== 1'b0) begin errors++; $display("FAIL lb_wait_w_valid[%0d]: got %b want 0", i, bus.m2_to_w_valid); end
    end
    cyc(); bus.m2_stall = 1'b0; bus.dmss_rvalid = 1'b1; bus.dmss_rdata = 32'h80FF_FF12;
    #1;
    checks++; if (bus.out_mem_rdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_rdata: got %h want ffffff80", bus.out_mem_rdata); end
    checks++; if (bus.m2_to_w_valid !== 1'b1) begin errors++; $display("FAIL lb_w_valid: got %b want 1", bus.m2_to_w_valid); end
    checks++; if (bus.fwd_rd_val !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_fwd_val: got %h want ffffff80", bus.fwd_rd_val); end
    checks++; if (bus.m2_ready !== 1'b1) begin errors++; $display("FAIL lb_ready: got %b want 1", bus.m2_ready); end
    cyc(); bus.dmss_rvalid = 1'b0;
    #1;
    checks++; if (bus.m2_to_w_valid !== 1'b0) begin errors++; $display("FAIL lb_after_w_valid: got %b want 0", bus.m2_to_w_valid); end
  endtask

  task automatic test_lhu_lw_lh();
    cyc(); drive_instr(5'd9, 1'b1, 2'd1, 32'h0000_2002, 32'h0, 1'b1, 2'd1, 1'b0);
    cyc(); drive_instr(5'd10, 1'b1, 2'd1, 32'h0000_3000, 32'h0, 1'b1, 2'd2, 1'b0);
    bus.dmss_rvalid = 1'b1; bus.dmss_rdata = 32'hBEEF_0000;
    #1;
    checks++; if (bus.out_mem_rdata !== 32'h0000_BEEF) begin errors++; $display("FAIL lhu_rdata: got %h want 0000beef", bus.out_mem_rdata); end
    checks++; if (bus.m2_to_w_valid !== 1'b1) begin errors++; $display("FAIL lhu_w_valid: got %b want 1", bus.m2_to_w_valid); end
    cyc(); drive_instr(5'd11, 1'b1, 2'd1, 32'h0000_4000, 32'h0, 1'b1, 2'd1, 1'b1);
    bus.dmss_rdata = 32'hCAFE_F00D;
    #1;
    checks++; if (bus.out_mem_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL lw_rdata: got %h want cafef00d", bus.out_mem_rdata); end
    checks++; if (bus.out_alu_result !== 32'h0000_3000) begin errors++; $display("FAIL lw_alu: got %h want 00003000", bus.out_alu_result); end
    checks++; if (bus.m2_to_w_valid !== 1'b1) begin errors++; $display("FAIL lw_w_valid: got %b want 1", bus.m2_to_w_valid); end
    cyc(); drive_bubble(); bus.dmss_rdata = 32'h1234_8001;
    #1;
    checks++; if (bus.out_mem_rdata !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_rdata: got %h want ffff8001", bus.out_mem_rdata); end
    cyc(); bus.dmss_rvalid = 1'b0;
    #1;
    checks++; if (bus.m2_ready !== 1'b1) begin errors++; $display("FAIL lh_after_ready: got %b want 1", bus.m2_ready); end
  endtask

  task automatic test_stall_hold();
    cyc(); drive_instr(5'd12, 1'b1, 2'd1, 32'h0000_5001, 32'h0, 1'b1, 2'd0, 1'b0);
    cyc(); drive_bubble(); bus.m2_stall = 1'b1; bus.dmss_rvalid = 1'b1; bus.dmss_rdata = 32'h0000_A500;
    #1;
    checks++; if (bus.m2_to_w_valid !== 1'b0) begin errors++; $display("FAIL hold_stalled_w_valid: got %b want 0", bus.m2_to_w_valid); end
    checks++; if (bus.m2_ready !== 1'b1) begin errors++; $display("FAIL hold_resp_ready: got %b want 1", bus.m2_ready); end
    cyc(); bus.dmss_rvalid = 1'b0; bus.dmss_rdata = 32'h0;
    #1;
    checks++; if (dut.state !== 2'd2) begin errors++; $display("FAIL hold_state: got %0d want 2", dut.state); end
    checks++; if (bus.m2_ready !== 1'b1) begin errors++; $display("FAIL hold_ready: got %b want 1", bus.m2_ready); end
    cyc(); bus.m2_stall = 1'b0;
    #1;
    checks++; if (bus.m2_to_w_valid !== 1'b1) begin errors++; $display("FAIL hold_release_w_valid: got %b want 1", bus.m2_to_w_valid); end
    checks++; if (bus.out_mem_rdata !== 32'h0000_00A5) begin errors++; $display("FAIL hold_rdata: got %h want 000000a5", bus.out_mem_rdata); end
    cyc(); #1;
    checks++; if (dut.state !== 2'd0) begin errors++; $display("FAIL hold_after_state: got %0d want 0", dut.state); end
  endtask

  task automatic test_flush_discard();
    cyc(); drive_instr(5'd13, 1'b1, 2'd1, 32'h0000_6000, 32'h0, 1'b1, 2'd2, 1'b0);
    cyc(); drive_bubble(); bus.m2_stall = 1'b1;
    cyc(); bus.m2_flush = 1'b1;
    #1;
    checks++; if (bus.m2_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b want 1", bus.m2_ready); end
    checks++; if (bus.m2_to_w_valid !== 1'b0) begin errors++; $display("FAIL flush_w_valid: got %b want 0", bus.m2_to_w_valid); end
    checks++; if (bus.fwd_valid !== 1'b0) begin errors++; $display("FAIL flush_fwd_valid: got %b want 0", bus.fwd_valid); end
    cyc(); bus.m2_flush = 1'b0; bus.m2_stall = 1'b0;
    drive_instr(5'd14, 1'b1, 2'd1, 32'h0000_7000, 32'h0, 1'b1, 2'd2, 1'b0);
    #1;
    checks++; if (dut.discard_cnt !== 2'd1) begin errors++; $display("FAIL flush_discard_cnt: got %0d want 1", dut.discard_cnt); end
    cyc(); drive_bubble(); bus.m2_stall = 1'b1; bus.dmss_rvalid = 1'b1; bus.dmss_rdata = 32'hAAAA_AAAA;
    #1;
    checks++; if (bus.m2_ready !== 1'b0) begin errors++; $display("FAIL discard_ready: got %b want 0", bus.m2_ready); end
    checks++; if (bus.m2_to_w_valid !== 1'b0) begin errors++; $display("FAIL discard_w_valid: got %b want 0", bus.m2_to_w_valid); end
    cyc(); bus.m2_stall = 1'b0; bus.dmss_rdata = 32'h5555_5555;
    #1;
    checks++; if (bus.out_mem_rdata !== 32'h5555_5555) begin errors++; $display("FAIL discard_rdata: got %h want 55555555", bus.out_mem_rdata); end
    checks++; if (bus.m2_to_w_valid !== 1'b1) begin errors++; $display("FAIL discard_after_w_valid: got %b want 1", bus.m2_to_w_valid); end
    checks++; if (bus.out_rd_idx !== 5'd14) begin errors++; $display("FAIL discard_rd_idx: got %0d want 14", bus.out_rd_idx); end
    cyc(); bus.dmss_rvalid = 1'b0;
    #1;
    checks++; if (dut.discard_cnt !== 2'd0) begin errors++; $display("FAIL discard_end_cnt: got %0d want 0", dut.discard_cnt); end
  endtask

  task automatic test_reset_mid();
    cyc(); drive_instr(5'd15, 1'b1, 2'd1, 32'h0000_8000, 32'h0, 1'b1, 2'd2, 1'b0);
    cyc(); drive_bubble(); bus.m2_stall = 1'b1; bus.m2_flush = 1'b1;
    cyc(); bus.m2_flush = 1'b0; bus.m2_stall = 1'b0;
    drive_instr(5'd16, 1'b1, 2'd1, 32'h0000_9000, 32'h0, 1'b1, 2'd2, 1'b0);
    cyc(); drive_bubble(); bus.m2_stall = 1'b1; rst_n = 1'b0;
    #1;
    checks++; if (dut.discard_cnt !== 2'd1) begin errors++; $display("FAIL rmid_pre_cnt: got %0d want 1", dut.discard_cnt); end
    cyc(); rst_n = 1'b1; bus.m2_stall = 1'b0;
    #1;
    checks++; if (dut.state !== 2'd0) begin errors++; $display("FAIL rmid_state: got %0d want 0", dut.state); end
    checks++; if (dut.discard_cnt !== 2'd0) begin errors++; $display("FAIL rmid_cnt: got %0d want 0", dut.discard_cnt); end
    checks++; if (bus.m2_to_w_valid !== 1'b0) begin errors++; $display("FAIL rmid_w_valid: got %b want 0", bus.m2_to_w_valid); end
    checks++; if (bus.m2_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %b want 1", bus.m2_ready); end
  endtask

  initial begin
    test_reset();
    test_alu_back_to_back();
    test_lb_signed();
    test_lhu_lw_lh();
    test_stall_hold();
    test_flush_discard();
    test_reset_mid();
    cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
